normalize_fp: RTL and testbench

NORMALIZE_FP -- requirements
Module: normalize_fp

---
 rtl/fp_add_pkg.sv | 70 +++++++
 rtl/lzc48_fp.sv | 25 ++
 rtl/normalize_fp.sv | 139 +++++++++++++
 tb/tb_normalize_fp.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_pkg
//  Description : Shared widths, sideband/result types and the normalisation
//                function used by the FP adder normaliser.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_add_pkg;

    localparam int RAW_W  = 49;
    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;
    localparam int GRS_W  = 24;
    localparam int LZC_W  = 6;
    localparam int SUM_W  = RAW_W - 1;

    typedef struct packed {
        logic       nan;
        logic       inf1;
        logic       inf2;
        logic       sign1;
        logic       sign2;
        logic       sign_res;
        logic [2:0] rm;
    } sideband_t;

    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic [GRS_W-1:0]  grs;
        logic              underflow;
    } norm_t;

    // sh holds the shifted magnitude with its leading one already dropped,
    // so the mantissa and GRS fields fall straight out of its upper/lower bits.
    function automatic norm_t normalize(
        input logic [RAW_W-1:0] sum,
        input logic [LZC_W-1:0] lzc,
        input logic [EXP_W-1:0] exp_in
    );
        norm_t            res;
        logic [SUM_W-2:0] sh;
        logic [EXP_W:0]   exp_inc;
        logic [EXP_W-1:0] lzc_ext;

        res     = '0;
        sh      = '0;
        lzc_ext = EXP_W'(lzc);
        exp_inc = {1'b0, exp_in} + (EXP_W+1)'(1);

        if (sum[RAW_W-1]) begin
            sh      = sum[SUM_W-1:1];
            sh[0]   = sum[1] | sum[0];
            res.exp = exp_inc[EXP_W] ? '1 : exp_inc[EXP_W-1:0];
        end else if (sum[SUM_W-1:0] != '0) begin
            if (lzc_ext < exp_in) begin
                sh      = sum[SUM_W-2:0] << lzc;
                res.exp = exp_in - lzc_ext;
            end else begin
                res.underflow = 1'b1;
            end
        end

        res.mant = sh[SUM_W-2:GRS_W];
        res.grs  = sh[GRS_W-1:0];
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lzc48_fp.sv
`default_nettype none
// ============================================================================
//  Module      : lzc48_fp
//  Description : Combinational 48-bit leading-zero counter (48 when all zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module lzc48_fp
    import fp_add_pkg::*;
(
    input  logic [SUM_W-1:0] i_data,
    output logic [LZC_W-1:0] o_count
);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        o_count = LZC_W'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            if (i_data[i]) begin
                o_count = LZC_W'(SUM_W - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/normalize_fp.sv
`default_nettype none
// ============================================================================
//  Module      : normalize_fp
//  Description : FP adder post-normaliser with valid/ready handshake.
//                Define NORMALIZE_FP_TWO_STAGE_EN for a 2-stage pipeline
//                (LZC registered first); default is a single registered stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module normalize_fp
    import fp_add_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RAW_W-1:0]  sum_raw,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              NaN,
    input  logic              inf1,
    input  logic              inf2,
    input  logic              sign1,
    input  logic              sign2,
    input  logic              sign_res,
    input  logic [2:0]        rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_norm,
    output logic [MANT_W-1:0] mantissa_norm,
    output logic [GRS_W-1:0]  grs,
    output logic              underflow,
    output logic              NaN_out,
    output logic              inf1_out,
    output logic              inf2_out,
    output logic              sign1_out,
    output logic              sign2_out,
    output logic              sign_res_out,
    output logic [2:0]        rm_out
);

    sideband_t        w_sb_in;
    sideband_t        w_sb_next;
    logic [LZC_W-1:0] w_lzc;
    norm_t            w_norm;
    logic             w_out_load;

    logic             r_out_valid;
    norm_t            r_out;
    sideband_t        r_out_sb;

    assign w_sb_in = {NaN, inf1, inf2, sign1, sign2, sign_res, rm};

    lzc48_fp u_lzc (
        .i_data  (sum_raw[SUM_W-1:0]),
        .o_count (w_lzc)
    );

`ifdef NORMALIZE_FP_TWO_STAGE_EN
    logic             r_s1_valid;
    logic [RAW_W-1:0] r_s1_sum;
    logic [LZC_W-1:0] r_s1_lzc;
    logic [EXP_W-1:0] r_s1_exp;
    sideband_t        r_s1_sb;
    logic             w_s1_load;

    assign w_out_load = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready   = !r_s1_valid || !r_out_valid || out_ready;
    assign w_s1_load  = in_valid && in_ready;

    // The carry flag travels as the top bit of r_s1_sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_lzc   <= '0;
            r_s1_exp   <= '0;
            r_s1_sb    <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_load) begin
                r_s1_valid <= 1'b1;
            end else if (w_out_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s1_load) begin
                r_s1_sum <= sum_raw;
                r_s1_lzc <= w_lzc;
                r_s1_exp <= exp_in;
                r_s1_sb  <= w_sb_in;
            end
        end
    end

    assign w_norm    = normalize(r_s1_sum, r_s1_lzc, r_s1_exp);
    assign w_sb_next = r_s1_sb;
`else
    assign in_ready   = !r_out_valid || out_ready;
    assign w_out_load = in_valid && in_ready;
    assign w_norm     = normalize(sum_raw, w_lzc, exp_in);
    assign w_sb_next  = w_sb_in;
`endif

    // Output stage only loads on an advance, so a stalled beat stays frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_sb    <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_out_load) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_load) begin
                r_out    <= w_norm;
                r_out_sb <= w_sb_next;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign exp_norm      = r_out.exp;
    assign mantissa_norm = r_out.mant;
    assign grs           = r_out.grs;
    assign underflow     = r_out.underflow;
    assign NaN_out       = r_out_sb.nan;
    assign inf1_out      = r_out_sb.inf1;
    assign inf2_out      = r_out_sb.inf2;
    assign sign1_out     = r_out_sb.sign1;
    assign sign2_out     = r_out_sb.sign2;
    assign sign_res_out  = r_out_sb.sign_res;
    assign rm_out        = r_out_sb.rm;

endmodule
`default_nettype wire

// File: tb/tb_normalize_fp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_normalize_fp
//  Description : Scoreboard bench for normalize_fp with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_normalize_fp;

`ifdef NORMALIZE_FP_TWO_STAGE_EN
    localparam int STALL_DEPTH = 2;
`else
    localparam int STALL_DEPTH = 1;
`endif
    localparam int NV = 14;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [48:0] sum_raw;
    logic [7:0]  exp_in;
    logic        NaN, inf1, inf2, sign1, sign2, sign_res;
    logic [2:0]  rm;
    logic [7:0]  exp_norm;
    logic [22:0] mantissa_norm;
    logic [23:0] grs;
    logic        underflow;
    logic        NaN_out, inf1_out, inf2_out, sign1_out, sign2_out, sign_res_out;
    logic [2:0]  rm_out;
    logic [8:0]  sb_out;

    assign sb_out = {NaN_out, inf1_out, inf2_out, sign1_out, sign2_out, sign_res_out, rm_out};

    normalize_fp dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum_raw(sum_raw), .exp_in(exp_in),
        .NaN(NaN), .inf1(inf1), .inf2(inf2), .sign1(sign1), .sign2(sign2),
        .sign_res(sign_res), .rm(rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_norm(exp_norm), .mantissa_norm(mantissa_norm), .grs(grs),
        .underflow(underflow),
        .NaN_out(NaN_out), .inf1_out(inf1_out), .inf2_out(inf2_out),
        .sign1_out(sign1_out), .sign2_out(sign2_out),
        .sign_res_out(sign_res_out), .rm_out(rm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [48:0] sum;
        logic [7:0]  ein;
        logic [7:0]  xexp;
        logic [22:0] xmant;
        logic [23:0] xgrs;
        logic        xuf;
    } vec_t;

    typedef struct packed {
        logic [7:0]  e;
        logic [22:0] m;
        logic [23:0] g;
        logic        uf;
        logic [8:0]  sb;
    } resp_t;

    vec_t  vecs [NV];
    resp_t sb_q [$];
    resp_t mon_exp, mon_act;
    int    n_tests = 0;
    int    n_fail = 0;
    int    n_accepted = 0;

    function automatic logic [8:0] sb_of(input int idx);
        return 9'((idx * 83 + 29) % 512);
    endfunction

    task automatic set_vec(input int i, input logic [48:0] s, input logic [7:0] e,
                           input logic [7:0] xe, input logic [22:0] xm,
                           input logic [23:0] xg, input logic xu);
        vecs[i].sum = s;   vecs[i].ein = e;   vecs[i].xexp = xe;
        vecs[i].xmant = xm; vecs[i].xgrs = xg; vecs[i].xuf = xu;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic drive_vec(input int idx);
        sum_raw = vecs[idx].sum;
        exp_in  = vecs[idx].ein;
        {NaN, inf1, inf2, sign1, sign2, sign_res, rm} = sb_of(idx);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic try_send(input int idx, input int max_cyc, output bit ok);
        resp_t r;
        ok = 1'b0;
        drive_vec(idx);
        in_valid = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (in_ready) begin
                r.e = vecs[idx].xexp;  r.m = vecs[idx].xmant;
                r.g = vecs[idx].xgrs;  r.uf = vecs[idx].xuf;
                r.sb = sb_of(idx);
                sb_q.push_back(r);
                n_accepted++;
                ok = 1'b1;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input int idx);
        bit ok;
        try_send(idx, 50, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout vec=%0d: got no in_ready, expected acceptance", idx);
        end
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d beats outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor: a transfer happens at the next posedge if valid&&ready now.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            n_tests++;
            mon_act = {exp_norm, mantissa_norm, grs, underflow, sb_out};
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got exp=%0h mant=%0h, expected no beat", exp_norm, mantissa_norm);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL beat: got exp=%0h mant=%0h grs=%0h uf=%0b sb=%0h, expected exp=%0h mant=%0h grs=%0h uf=%0b sb=%0h",
                             mon_act.e, mon_act.m, mon_act.g, mon_act.uf, mon_act.sb,
                             mon_exp.e, mon_exp.m, mon_exp.g, mon_exp.uf, mon_exp.sb);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int acc0;

        set_vec(0,  49'h1_0000_0000_0000, 8'd127, 8'd128, 23'h0,      24'h0,      1'b0);
        set_vec(1,  49'h0_1000_0000_0000, 8'd130, 8'd127, 23'h0,      24'h0,      1'b0);
        set_vec(2,  49'h0_0100_0000_0000, 8'd3,   8'd0,   23'h0,      24'h0,      1'b1);
        set_vec(3,  49'h0_0000_0000_0000, 8'd50,  8'd0,   23'h0,      24'h0,      1'b0);
        set_vec(4,  49'h1_0000_0000_0001, 8'd100, 8'd101, 23'h0,      24'h000001, 1'b0);
        set_vec(5,  49'h1_8000_0000_0003, 8'd10,  8'd11,  23'h400000, 24'h000001, 1'b0);
        set_vec(6,  49'h1_0000_0000_0000, 8'd254, 8'd255, 23'h0,      24'h0,      1'b0);
        set_vec(7,  49'h0_C000_0012_3456, 8'd5,   8'd5,   23'h400000, 24'h123456, 1'b0);
        set_vec(8,  49'h0_1000_0000_0000, 8'd4,   8'd1,   23'h0,      24'h0,      1'b0);
        set_vec(9,  49'h0_1000_0000_0000, 8'd3,   8'd0,   23'h0,      24'h0,      1'b1);
        set_vec(10, 49'h0_0000_0000_0003, 8'd100, 8'd54,  23'h400000, 24'h0,      1'b0);
        set_vec(11, 49'h0_0000_0180_0001, 8'd30,  8'd7,   23'h400000, 24'h800000, 1'b0);
        set_vec(12, 49'h0_8000_0000_0000, 8'd0,   8'd0,   23'h0,      24'h0,      1'b1);
        set_vec(13, 49'h1_FFFF_FFFF_FFFF, 8'd200, 8'd201, 23'h7FFFFF, 24'hFFFFFF, 1'b0);

        // Reset with live-looking inputs: outputs must stay cleared.
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive_vec(13);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'({exp_norm, mantissa_norm, grs, underflow}), 64'd0);
        check("rst_sideband", 64'(sb_out), 64'd0);
        in_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back directed vectors, out_ready held high.
        for (int i = 0; i < NV; i++) send(i);
        drain("stream");

        // Same vectors against an irregular out_ready pattern.
        fork
            begin
                for (int i = 0; i < NV; i++) send(i);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = (c % 3) != 0;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("toggle");

        // Backpressure: three beats offered, consumer stalled five cycles.
        out_ready = 1'b0;
        acc0 = n_accepted;
        fork
            begin
                send(5); send(6); send(7);
            end
            begin
                repeat (5) begin
                    @(posedge clk); #1;
                end
                check("stall_accepted", 64'(n_accepted - acc0), 64'(STALL_DEPTH));
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'({exp_norm, mantissa_norm}), 64'({vecs[5].xexp, vecs[5].xmant}));
                out_ready = 1'b1;
            end
        join
        drain("stall");

        // Asynchronous reset with beats in flight.
        out_ready = 1'b0;
        try_send(0, 2, ok);
        try_send(1, 2, ok);
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_data", 64'({exp_norm, mantissa_norm, grs}), 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("post_reset_no_stale", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(4);
        drain("post_reset");

        // Synchronous flush with beats in flight.
        out_ready = 1'b0;
        try_send(2, 2, ok);
        try_send(3, 2, ok);
        check("pre_flush_out_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("post_flush_no_stale", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(5);
        drain("post_flush");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
